tone_frame_reader: RTL and testbench
====================================

TONE_FRAME_READER -- requirements
Module: tone_frame_reader

Interface
REQ-001 The block SHALL have one clock and SHALL use synchronous, active-low reset; the ports are clk and rst_n.
REQ-002 The block SHALL provide the following parameters, one per line:
  DATA_W, 12, sample width in bits (two's complement).
  FRAME_LEN, 256, samples per frame (power of two).
  ADDR_W, 8, buffer address width, log2(FRAME_LEN).
  GAP_CYCLES, 16, idle cycles between end of capture and start of readout (range 0..255).
REQ-003 The block SHALL provide the following ports, one per line:
  clk  input  1  system clock.
  rst_n  input  1  synchronous active-low reset.
  adc_data  input  DATA_W  signed ADC sample.
  adc_valid  input  1  adc_data is valid this cycle.
  capture_start  input  1  single-cycle request to capture and replay one frame.
  tone_signal  output  DATA_W  signed replayed sample, feeding the FFT correction path.
  tone_signal_valid  output  1  tone_signal is valid this cycle.
  busy  output  1  high from an accepted capture_start until frame_done.
  frame_done  output  1  single-cycle pulse after the last replayed sample.

Function
REQ-004 The block SHALL contain an inferred single-port-write, single-port-read memory of FRAME_LEN x DATA_W with 1-cycle registered read latency.
REQ-005 The block SHALL implement the states IDLE, CAPTURE, GAP, READ and DONE.
REQ-006 IDLE: capture_start=1 SHALL move the block to CAPTURE on the next cycle and clear the write address to 0; a sample presented in the same cycle as capture_start SHALL NOT be stored.
REQ-007 CAPTURE: each cycle with adc_valid=1 SHALL write adc_data at the write address and increment it; cycles with adc_valid=0 SHALL write nothing (gaps are allowed and unbounded).
REQ-008 CAPTURE: the write of address FRAME_LEN-1 SHALL move the block to GAP on the next cycle and load the gap counter with GAP_CYCLES.
REQ-009 GAP: the block SHALL wait GAP_CYCLES cycles and then enter READ; when GAP_CYCLES=0 it SHALL enter READ the cycle after the last write.
REQ-010 READ: the block SHALL issue read addresses 0..FRAME_LEN-1 on consecutive cycles, with no stalls.
REQ-011 tone_signal_valid SHALL be high exactly one cycle after each read address is issued, giving FRAME_LEN consecutive valid cycles; tone_signal SHALL equal the captured sample k on the k-th valid cycle (k from 0).
REQ-012 After the last read address the block SHALL enter DONE; frame_done SHALL pulse high for one cycle, coincident with the cycle after the final tone_signal_valid, and the block SHALL then return to IDLE.
REQ-013 busy SHALL be high from the cycle after an accepted capture_start through the frame_done cycle inclusive, and low in IDLE.
REQ-014 capture_start SHALL be ignored in every state other than IDLE, including the frame_done cycle.
REQ-015 When tone_signal_valid=0, tone_signal SHALL be driven to 0.
REQ-016 adc_valid SHALL be ignored outside CAPTURE, and no write SHALL occur outside CAPTURE.
REQ-017 The address counters SHALL be ADDR_W bits wide, and termination SHALL be decided by comparing against FRAME_LEN-1, not by wrap-around.
REQ-018 The data path SHALL pass samples bit-exact, with no scaling, sign extension or truncation.

Reset
REQ-019 While rst_n=0 at a clock edge, the block SHALL go to IDLE and drive tone_signal=0, tone_signal_valid=0, busy=0 and frame_done=0, and the address and gap counters SHALL reset to 0.
REQ-020 Reset in any state (mid-capture, mid-gap, mid-read) SHALL abort the frame immediately, with no further valid or frame_done output; memory contents SHALL NOT be cleared.
REQ-021 After reset deasserts, the first capture_start SHALL behave per REQ-006.

Verification
REQ-022 The bench SHALL cover at least the following directed scenarios:
  Basic: capture_start, then 256 contiguous valid samples 0,1,...,255 (12-bit), GAP_CYCLES=16 -> after the last write, 16 idle cycles, then 256 contiguous valid outputs 0..255 in order, frame_done pulse the cycle after output 255, busy falls after frame_done.
  Gapped input: adc_valid toggling 1,0,1,0 with values -2048, 2047, -1, 1 repeated -> output sequence identical and contiguous, with signs preserved (0x800, 0x7FF, 0xFFF, 0x001).
  Start collision: capture_start asserted in the same cycle as adc_valid with value 0x123 -> 0x123 is not captured; the first stored sample is the next valid one.
  Ignored start: capture_start pulsed during CAPTURE, GAP, READ and on the frame_done cycle -> no restart, exactly one frame of 256 valid outputs, busy behaviour unchanged.
  Reset mid-read: rst_n low for 1 cycle after 100 valid outputs -> tone_signal_valid=0 and busy=0 the next cycle, no frame_done; a new capture_start then yields a clean 256-sample frame.
  GAP_CYCLES=0: readout begins the cycle after the last write, so the first tone_signal_valid appears 2 cycles after the final capture write.

Source files
------------

// File: rtl/tone_frame_reader.sv
// Captures one frame of ADC samples into an on-chip buffer, waits a programmable
// gap, then replays the frame as a contiguous stream for the FFT correction path.
module tone_frame_reader #(
   parameter int DATA_W     = 12,
   parameter int FRAME_LEN  = 256,
   parameter int ADDR_W     = 8,
   parameter int GAP_CYCLES = 16
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic signed [DATA_W-1:0] adc_data,
   input  logic                     adc_valid,
   input  logic                     capture_start,
   output logic signed [DATA_W-1:0] tone_signal,
   output logic                     tone_signal_valid,
   output logic                     busy,
   output logic                     frame_done
);

   localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(FRAME_LEN - 1);
   localparam logic [ADDR_W-1:0] ADDR_ONE  = ADDR_W'(1);
   localparam logic [7:0]        GAP_LOAD  = 8'(GAP_CYCLES);

   typedef enum logic [2:0] {
      IDLE,
      CAPTURE,
      GAP,
      READ,
      DONE
   } state_t;

   state_t                   state;
   logic [ADDR_W-1:0]        wr_addr;
   logic [ADDR_W-1:0]        rd_addr;
   logic [7:0]               gap_cnt;
   logic                     wr_en_p0;
   logic                     rd_en_p0;
   logic                     vld_p1;
   logic signed [DATA_W-1:0] rd_data_p1;
   logic signed [DATA_W-1:0] mem [0:FRAME_LEN-1];

   // A write is blocked on the reset edge so an aborted capture cannot land one more sample.
   assign wr_en_p0 = rst_n && (state == CAPTURE) && adc_valid;
   assign rd_en_p0 = (state == READ);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state      <= IDLE;
         wr_addr    <= '0;
         rd_addr    <= '0;
         gap_cnt    <= '0;
         busy       <= 1'b0;
         frame_done <= 1'b0;
         vld_p1     <= 1'b0;
      end else begin
         vld_p1     <= rd_en_p0;
         frame_done <= 1'b0;
         unique case (state)
            IDLE: begin
               if (capture_start) begin
                  state   <= CAPTURE;
                  wr_addr <= '0;
                  busy    <= 1'b1;
               end
            end
            CAPTURE: begin
               if (adc_valid) begin
                  wr_addr <= wr_addr + ADDR_ONE;
                  if (wr_addr == LAST_ADDR) begin
                     rd_addr <= '0;
                     gap_cnt <= GAP_LOAD;
                     state   <= (GAP_LOAD == 8'd0) ? READ : GAP;
                  end
               end
            end
            GAP: begin
               gap_cnt <= gap_cnt - 8'd1;
               if (gap_cnt <= 8'd1) begin
                  state <= READ;
               end
            end
            READ: begin
               rd_addr <= rd_addr + ADDR_ONE;
               if (rd_addr == LAST_ADDR) begin
                  state <= DONE;
               end
            end
            DONE: begin
               // First DONE cycle drains the read pipeline; the second carries frame_done.
               if (!frame_done) begin
                  frame_done <= 1'b1;
               end else begin
                  state <= IDLE;
                  busy  <= 1'b0;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   // ---- p0 -> p1: buffer write and registered read ----
   always_ff @(posedge clk) begin
      if (wr_en_p0) begin
         mem[wr_addr] <= adc_data;
      end
      if (rd_en_p0) begin
         rd_data_p1 <= mem[rd_addr];
      end
   end

   // ---- p1: output ----
   assign tone_signal       = vld_p1 ? rd_data_p1 : '0;
   assign tone_signal_valid = vld_p1;

endmodule

// File: tb/tb_tone_frame_reader.sv
// Scoreboard bench for tone_frame_reader: inst 0 uses GAP_CYCLES=16, inst 1 uses GAP_CYCLES=0.
module tb_tone_frame_reader;

   localparam int DATA_W = 12;

   logic              clk = 1'b0;
   logic              rst_n;
   logic [DATA_W-1:0] adc_data;
   logic              adc_valid;
   logic              cs0, cs1;
   logic [DATA_W-1:0] ts0, ts1;
   logic              tv0, tv1, bz0, bz1, fd0, fd1;

   int n_checks = 0;
   int n_errs   = 0;
   int cyc      = 0;

   logic [DATA_W-1:0] q0[$];
   logic [DATA_W-1:0] q1[$];
   int  run_len [2];
   int  frames  [2];
   int  lw_cyc  [2];
   bit  prev_v  [2];
   bit  prev_f  [2];
   bit  lat_chk [2];
   logic [DATA_W-1:0] pat [4] = '{12'h800, 12'h7FF, 12'hFFF, 12'h001};

   tone_frame_reader #(.DATA_W(12), .FRAME_LEN(256), .ADDR_W(8), .GAP_CYCLES(16)) dut_g16 (
      .clk(clk), .rst_n(rst_n), .adc_data(adc_data), .adc_valid(adc_valid),
      .capture_start(cs0), .tone_signal(ts0), .tone_signal_valid(tv0),
      .busy(bz0), .frame_done(fd0));

   tone_frame_reader #(.DATA_W(12), .FRAME_LEN(256), .ADDR_W(8), .GAP_CYCLES(0)) dut_g0 (
      .clk(clk), .rst_n(rst_n), .adc_data(adc_data), .adc_valid(adc_valid),
      .capture_start(cs1), .tone_signal(ts1), .tone_signal_valid(tv1),
      .busy(bz1), .frame_done(fd1));

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errs++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   function automatic logic busy_of(input int i);
      return (i == 0) ? bz0 : bz1;
   endfunction

   function automatic logic fd_of(input int i);
      return (i == 0) ? fd0 : fd1;
   endfunction

   task automatic set_cs(input int i, input logic val);
      if (i == 0) cs0 = val;
      else cs1 = val;
   endtask

   task automatic push(input int i, input logic [DATA_W-1:0] d);
      if (i == 0) q0.push_back(d);
      else q1.push_back(d);
   endtask

   // Monitor: pops expected samples and checks framing/handshake on every cycle.
   always @(negedge clk) begin
      logic [DATA_W-1:0] t, e;
      logic v, b, f;
      int qs, gapv;
      for (int i = 0; i < 2; i++) begin
         t    = (i == 0) ? ts0 : ts1;
         v    = (i == 0) ? tv0 : tv1;
         b    = (i == 0) ? bz0 : bz1;
         f    = (i == 0) ? fd0 : fd1;
         qs   = (i == 0) ? q0.size() : q1.size();
         gapv = (i == 0) ? 16 : 0;
         if (v) begin
            if (lat_chk[i] && run_len[i] == 0) begin
               check("first_vld_latency", cyc - lw_cyc[i], gapv + 2);
               lat_chk[i] = 0;
            end
            check("busy_during_read", {31'b0, b}, 1);
            if (qs == 0) begin
               check("spurious_vld", {31'b0, v}, 0);
            end else begin
               e = (i == 0) ? q0.pop_front() : q1.pop_front();
               check("sample", {20'b0, t}, {20'b0, e});
            end
            run_len[i]++;
         end else begin
            check("zero_when_invalid", {20'b0, t}, 0);
            if (prev_v[i] && !f) check("vld_contiguous", {31'b0, v}, 1);
         end
         if (f) begin
            check("fd_after_last_vld", {31'b0, prev_v[i]}, 1);
            check("fd_busy_high", {31'b0, b}, 1);
            check("frame_len", run_len[i], 256);
            frames[i]++;
            run_len[i] = 0;
         end
         if (prev_f[i]) check("busy_fall_after_fd", {31'b0, b}, 0);
         prev_v[i] = v;
         prev_f[i] = f;
      end
   end

   task automatic start(input int i, input bit collide);
      @(posedge clk); #1;
      check("busy_idle", {31'b0, busy_of(i)}, 0);
      set_cs(i, 1'b1);
      adc_valid = collide;
      adc_data  = 12'h123;
      @(posedge clk); #1;
      set_cs(i, 1'b0);
      adc_valid = 1'b0;
      check("busy_rise", {31'b0, busy_of(i)}, 1);
   endtask

   // mode 0: ramp, 1: toggling valid with extreme values, 2: scrambled ramp
   task automatic feed(input int i, input int mode, input bit poke, input bit junk);
      int n, t;
      logic vld;
      logic [DATA_W-1:0] d;
      n = 0;
      t = 0;
      while (n < 256) begin
         @(posedge clk); #1;
         vld = 1'b1;
         d   = 12'(n);
         if (mode == 1) begin
            vld = (t % 2 == 0);
            d   = vld ? pat[n % 4] : 12'h5A5;
         end else if (mode == 2) begin
            d = 12'(n * 7 + 3);
         end
         adc_valid = vld;
         adc_data  = d;
         set_cs(i, poke && n == 50);
         if (vld) begin
            push(i, d);
            n++;
            if (n == 256) begin
               lw_cyc[i]  = cyc;
               lat_chk[i] = 1;
            end
         end
         t++;
      end
      // Inputs during the gap must neither restart nor write the buffer.
      for (int k = 0; k < 4; k++) begin
         @(posedge clk); #1;
         set_cs(i, poke && k == 1);
         adc_valid = junk;
         adc_data  = 12'h3C3;
      end
      @(posedge clk); #1;
      set_cs(i, 1'b0);
      adc_valid = 1'b0;
   endtask

   task automatic wait_done(input int i, input bit poke);
      int f0, g;
      bit read_poked;
      f0 = frames[i];
      g = 0;
      read_poked = 0;
      while (frames[i] == f0 && g < 3000) begin
         @(posedge clk); #1;
         g++;
         set_cs(i, 1'b0);
         if (poke && !read_poked && run_len[i] >= 10) begin
            set_cs(i, 1'b1);
            read_poked = 1;
         end
         if (poke && fd_of(i)) set_cs(i, 1'b1);
      end
      if (g >= 3000) check("frame_done_timeout", g, 0);
      @(posedge clk); #1;
      set_cs(i, 1'b0);
      check("busy_low_after_frame", {31'b0, busy_of(i)}, 0);
      check("queue_drained", (i == 0) ? q0.size() : q1.size(), 0);
      repeat (6) @(posedge clk);
      #1;
      check("no_restart", {31'b0, busy_of(i)}, 0);
   endtask

   initial begin
      int g, f0;
      for (int i = 0; i < 2; i++) begin
         run_len[i] = 0; frames[i] = 0; lw_cyc[i] = 0;
         prev_v[i] = 0; prev_f[i] = 0; lat_chk[i] = 0;
      end
      rst_n = 1'b0; cs0 = 1'b0; cs1 = 1'b0; adc_valid = 1'b0; adc_data = '0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_ts0", {20'b0, ts0}, 0);
      check("rst_tv0", {31'b0, tv0}, 0);
      check("rst_busy0", {31'b0, bz0}, 0);
      check("rst_fd0", {31'b0, fd0}, 0);
      check("rst_tv1", {31'b0, tv1}, 0);
      check("rst_busy1", {31'b0, bz1}, 0);
      rst_n = 1'b1;

      // Basic ramp, with valid junk driven during the gap
      start(0, 0); feed(0, 0, 0, 1); wait_done(0, 0);
      // Gapped input with full-scale signed values
      start(0, 0); feed(0, 1, 0, 0); wait_done(0, 0);
      // Start collides with a valid sample
      start(0, 1); feed(0, 2, 0, 0); wait_done(0, 0);
      // Starts pulsed in CAPTURE, GAP, READ and on the frame_done cycle
      start(0, 0); feed(0, 0, 1, 0); wait_done(0, 1);

      // Reset in the middle of readout
      start(0, 0); feed(0, 2, 0, 0);
      g = 0;
      while (run_len[0] < 100 && g < 3000) begin
         @(posedge clk); #1;
         g++;
      end
      check("reached_100_outputs", {31'b0, run_len[0] >= 100}, 1);
      rst_n = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b1;
      q0.delete();
      run_len[0] = 0; prev_v[0] = 0; lat_chk[0] = 0;
      check("abort_vld", {31'b0, tv0}, 0);
      check("abort_busy", {31'b0, bz0}, 0);
      check("abort_fd", {31'b0, fd0}, 0);
      f0 = frames[0];
      repeat (300) @(posedge clk);
      #1;
      check("no_fd_after_abort", frames[0], f0);
      start(0, 0); feed(0, 0, 0, 0); wait_done(0, 0);

      // Zero-gap instance
      start(1, 0); feed(1, 1, 0, 0); wait_done(1, 0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errs);
      $finish;
   end

endmodule
